// File: rtl/sseg_scan_mux.sv
// Time-multiplexed 4-digit common-anode 7-segment driver.
// Each digit gets a blanking gap followed by its on-slot; all outputs registered.
module sseg_scan_mux #(
    parameter int SLOT_CYCLES = 50000,
    parameter int DEAD_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [3:0] en,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int CMAX = (SLOT_CYCLES > DEAD_CYCLES) ? SLOT_CYCLES : DEAD_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic {BLANK, ON} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      idx, idx_n;
    logic [7:0]      pat, pat_n;
    logic            den, den_n;
    logic            tick_n;
    logic [3:0]      an_n;
    logic [7:0]      sseg_n;
    logic [7:0]      in_sel;

    always_comb begin
        in_sel = in0;
        case (idx)
            2'd0: in_sel = in0;
            2'd1: in_sel = in1;
            2'd2: in_sel = in2;
            2'd3: in_sel = in3;
            default: in_sel = in0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        pat_n   = pat;
        den_n   = den;
        tick_n  = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CW'(DEAD_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = ON;
                    pat_n   = in_sel;
                    den_n   = en[idx];
                end
            end
            ON: begin
                if (cnt == CW'(SLOT_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = BLANK;
                    idx_n   = idx + 2'd1;
                    tick_n  = (idx == 2'd3);
                end
            end
            default: state_n = BLANK;
        endcase
        // Drive from next-state so the anode flips on the same edge as the state.
        an_n   = 4'hF;
        sseg_n = 8'hFF;
        if (state_n == ON && den_n) begin
            an_n   = ~(4'b0001 << idx_n);
            sseg_n = pat_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            pat        <= 8'hFF;
            den        <= 1'b0;
            an         <= 4'hF;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            pat        <= pat_n;
            den        <= den_n;
            an         <= an_n;
            sseg       <= sseg_n;
            frame_tick <= tick_n;
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux with SLOT=8, DEAD=2 (digit period 10, frame 40).
module tb_sseg_scan_mux;

    localparam int SLOT = 8;
    localparam int DEAD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] en;
    logic [3:0] an;
    logic [7:0] sseg;
    logic [1:0] digit_idx;
    logic       frame_tick;

    int nvec = 0;
    int nmis = 0;
    bit mon_on = 1'b0;

    logic [7:0] epat [4];
    logic [3:0] een;

    sseg_scan_mux #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .reset(reset),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .en(en), .an(an), .sseg(sseg),
        .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // t counts cycles since the last reset edge: pos 0..1 blank, 2..9 lit.
    task automatic check_cycle(input int t);
        int pos, d;
        logic [3:0] ea;
        logic [7:0] es;
        pos = t % 10;
        d   = (t / 10) % 4;
        ea  = 4'hF;
        es  = 8'hFF;
        if (pos >= 2 && een[d]) begin
            ea = ~(4'b0001 << d);
            es = epat[d];
        end
        chk($sformatf("an@%0d", t), {28'd0, an}, {28'd0, ea});
        chk($sformatf("sseg@%0d", t), {24'd0, sseg}, {24'd0, es});
        chk($sformatf("idx@%0d", t), {30'd0, digit_idx}, d);
        chk($sformatf("tick@%0d", t), {31'd0, frame_tick}, (t > 0 && t % 40 == 0) ? 1 : 0);
    endtask

    always @(negedge clk)
        if (mon_on) chk("onehot", $countones(~an) <= 1, 1);

    initial begin
        reset = 1'b1;
        in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
        en  = 4'b1111;
        epat[0] = 8'hC0; epat[1] = 8'hF9; epat[2] = 8'hA4; epat[3] = 8'hB0;
        een = 4'b1111;
        repeat (3) step();
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_sseg", {24'd0, sseg}, 32'hFF);
        chk("rst_idx", {30'd0, digit_idx}, 0);
        chk("rst_tick", {31'd0, frame_tick}, 0);
        mon_on = 1'b1;
        reset = 1'b0;

        // Five frames: full scan, in1 change mid-slot, then en=1010.
        for (int t = 1; t < 186; t++) begin
            step();
            check_cycle(t);
            if (t == 56) in1 = 8'h99;        // cnt=4 of digit 1's slot
            if (t == 59) epat[1] = 8'h99;    // visible only from next digit-1 slot
            if (t == 115) en = 4'b1010;
            if (t == 119) een = 4'b1010;
        end

        // Reset pulse during digit 2's on-slot of the fifth frame.
        reset = 1'b1;
        en = 4'b1111;
        step();
        chk("mid_rst_an", {28'd0, an}, 32'hF);
        chk("mid_rst_sseg", {24'd0, sseg}, 32'hFF);
        chk("mid_rst_idx", {30'd0, digit_idx}, 0);
        chk("mid_rst_tick", {31'd0, frame_tick}, 0);
        reset = 1'b0;
        een = 4'b1111;
        for (int t = 1; t < 14; t++) begin
            step();
            check_cycle(t);
        end

        // Random stress: one-hot anode monitor runs every cycle.
        for (int c = 0; c < 40000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                in0 = 8'($urandom); in1 = 8'($urandom);
                in2 = 8'($urandom); in3 = 8'($urandom);
                en  = 4'($urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
